// File: rtl/relogio_pkg.sv
// rtl/relogio_pkg.sv - shared types, limits and BCD split for the HH:MM:SS clock
package relogio_pkg;

    typedef enum logic [1:0] {RUN, SET_H, SET_M} set_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [5:0] MAX_SEC   = 6'd59;
    localparam logic [5:0] MAX_MIN   = 6'd59;
    localparam logic [4:0] MAX_HOUR  = 5'd23;

    // Values never exceed 59, so a compare/subtract ladder replaces a divider.
    function automatic logic [7:0] to_bcd2(input logic [6:0] v);
        logic [3:0] msd;
        logic [3:0] lsd;
        if (v >= 7'd50) begin
            msd = 4'd5;
            lsd = 4'(v - 7'd50);
        end else if (v >= 7'd40) begin
            msd = 4'd4;
            lsd = 4'(v - 7'd40);
        end else if (v >= 7'd30) begin
            msd = 4'd3;
            lsd = 4'(v - 7'd30);
        end else if (v >= 7'd20) begin
            msd = 4'd2;
            lsd = 4'(v - 7'd20);
        end else if (v >= 7'd10) begin
            msd = 4'd1;
            lsd = 4'(v - 7'd10);
        end else begin
            msd = 4'd0;
            lsd = 4'(v);
        end
        return {msd, lsd};
    endfunction

endpackage

// File: rtl/bcd_7seg.sv
// rtl/bcd_7seg.sv - BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}
module bcd_7seg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/relogio_hms_ajustavel.sv
// rtl/relogio_hms_ajustavel.sv - settable HH:MM:SS clock with 12/24 h display; optional alarm under ALARM_EN
module relogio_hms_ajustavel
    import relogio_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BLINK_DIV   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       mode_12h,
`ifdef ALARM_EN
    input  logic       alarm_set,
    output logic       alarm,
`endif
    output logic [6:0] s_lsd,
    output logic [6:0] s_msd,
    output logic [6:0] m_lsd,
    output logic [6:0] m_msd,
    output logic [6:0] h_lsd,
    output logic [6:0] h_msd,
    output logic       pm,
    output logic       tick_1hz
);

    localparam int DIV_W     = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int BLINK_LEN = CLK_FREQ_HZ / BLINK_DIV;
    localparam int BLK_W     = (BLINK_LEN > 1) ? $clog2(BLINK_LEN) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ_HZ - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_LEN - 1);

    set_state_t       state;
    logic [DIV_W-1:0] div_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_ph;
    logic [5:0]       sec;
    logic [5:0]       min;
    logic [4:0]       hour;

    logic       tick;
    logic       sec_wrap, min_wrap, hour_wrap;
    logic [5:0] sec_tick, min_tick;
    logic [4:0] hour_tick;

    assign tick      = (state == RUN) && (div_cnt == DIV_LAST);
    assign tick_1hz  = tick;
    assign sec_wrap  = (sec == MAX_SEC);
    assign min_wrap  = (min == MAX_MIN);
    assign hour_wrap = (hour == MAX_HOUR);
    assign sec_tick  = sec_wrap ? 6'd0 : sec + 6'd1;
    assign min_tick  = sec_wrap ? (min_wrap ? 6'd0 : min + 6'd1) : min;
    assign hour_tick = (sec_wrap && min_wrap) ? (hour_wrap ? 5'd0 : hour + 5'd1) : hour;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            div_cnt <= '0;
            sec     <= '0;
            min     <= '0;
            hour    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (tick) begin
                        div_cnt <= '0;
                        sec     <= sec_tick;
                        min     <= min_tick;
                        hour    <= hour_tick;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (btn_mode)
                        state <= SET_H;
                end
                SET_H: begin
                    if (btn_mode)
                        state <= SET_M;
                    else if (btn_inc)
                        hour <= hour_wrap ? 5'd0 : hour + 5'd1;
                end
                SET_M: begin
                    // Restart the second cleanly so the new minute begins on a full second.
                    if (btn_mode) begin
                        state   <= RUN;
                        sec     <= '0;
                        div_cnt <= '0;
                    end else if (btn_inc) begin
                        min <= min_wrap ? 6'd0 : min + 6'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Any button press restarts the blink in the visible phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (state == RUN || btn_mode || btn_inc) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

`ifdef ALARM_EN
    logic [4:0] al_hour;
    logic [5:0] al_min;
    logic [5:0] al_secs;
    logic       alarm_q;
    logic       fire;

    assign fire  = tick && sec_wrap && (min_tick == al_min) && (hour_tick == al_hour);
    assign alarm = alarm_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            al_hour <= '0;
            al_min  <= '0;
            al_secs <= '0;
            alarm_q <= 1'b0;
        end else begin
            if (alarm_set) begin
                al_hour <= hour;
                al_min  <= min;
            end
            if (btn_mode || btn_inc) begin
                alarm_q <= 1'b0;
            end else if (fire) begin
                alarm_q <= 1'b1;
                al_secs <= '0;
            end else if (alarm_q && tick) begin
                if (al_secs == MAX_SEC)
                    alarm_q <= 1'b0;
                else
                    al_secs <= al_secs + 6'd1;
            end
        end
    end
`endif

    logic [4:0] hour_disp;

    always_comb begin
        hour_disp = hour;
        if (mode_12h) begin
            if (hour == 5'd0)
                hour_disp = 5'd12;
            else if (hour > 5'd12)
                hour_disp = hour - 5'd12;
        end
    end

    assign pm = (hour >= 5'd12);

    logic [7:0] sec_bcd, min_bcd, hour_bcd;
    logic [6:0] m_lsd_raw, m_msd_raw, h_lsd_raw, h_msd_raw;
    logic       blank_h, blank_m;

    assign sec_bcd  = to_bcd2({1'b0, sec});
    assign min_bcd  = to_bcd2({1'b0, min});
    assign hour_bcd = to_bcd2({2'b00, hour_disp});

    bcd_7seg u_s_lsd (.digit(sec_bcd[3:0]),  .seg(s_lsd));
    bcd_7seg u_s_msd (.digit(sec_bcd[7:4]),  .seg(s_msd));
    bcd_7seg u_m_lsd (.digit(min_bcd[3:0]),  .seg(m_lsd_raw));
    bcd_7seg u_m_msd (.digit(min_bcd[7:4]),  .seg(m_msd_raw));
    bcd_7seg u_h_lsd (.digit(hour_bcd[3:0]), .seg(h_lsd_raw));
    bcd_7seg u_h_msd (.digit(hour_bcd[7:4]), .seg(h_msd_raw));

    assign blank_h = (state == SET_H) && blink_ph;
    assign blank_m = (state == SET_M) && blink_ph;
    assign m_lsd   = blank_m ? SEG_BLANK : m_lsd_raw;
    assign m_msd   = blank_m ? SEG_BLANK : m_msd_raw;
    assign h_lsd   = blank_h ? SEG_BLANK : h_lsd_raw;
    assign h_msd   = blank_h ? SEG_BLANK : h_msd_raw;

endmodule

// File: tb/tb_relogio_hms_ajustavel.sv
// tb/tb_relogio_hms_ajustavel.sv - directed self-checking bench, CLK_FREQ_HZ=8 BLINK_DIV=2; ALARM_EN adds the alarm scenario
module tb_relogio_hms_ajustavel;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_inc = 1'b0;
    logic mode_12h = 1'b0;
    logic [6:0] s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd;
    logic pm, tick_1hz;
`ifdef ALARM_EN
    logic alarm_set = 1'b0;
    logic alarm;
`endif
    logic [41:0] disp;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    relogio_hms_ajustavel #(.CLK_FREQ_HZ(8), .BLINK_DIV(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .mode_12h (mode_12h),
`ifdef ALARM_EN
        .alarm_set(alarm_set),
        .alarm    (alarm),
`endif
        .s_lsd    (s_lsd),
        .s_msd    (s_msd),
        .m_lsd    (m_lsd),
        .m_msd    (m_msd),
        .h_lsd    (h_lsd),
        .h_msd    (h_msd),
        .pm       (pm),
        .tick_1hz (tick_1hz)
    );

    assign disp = {h_msd, h_lsd, m_msd, m_lsd, s_msd, s_lsd};

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] exp_disp(input int h, input int m, input int s);
        return {seg_of(h / 10), seg_of(h % 10), seg_of(m / 10), seg_of(m % 10),
                seg_of(s / 10), seg_of(s % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_mode;
        btn_mode = 1'b1;
        @(negedge clock);
        btn_mode = 1'b0;
    endtask

    task automatic pulse_inc;
        btn_inc = 1'b1;
        @(negedge clock);
        btn_inc = 1'b0;
    endtask

    task automatic inc_n(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_inc;
            if (i != n - 1) step(1);
        end
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b0;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        mode_12h = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic wait_tick;
        for (int i = 0; i < 20 && tick_1hz !== 1'b1; i++) @(negedge clock);
        if (tick_1hz !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: tick_1hz=%b required 1 within 20 cycles", tick_1hz);
        end
    endtask

    task automatic test_reset;
        logic [41:0] e;
        do_reset;
        total++;
        if (disp !== exp_disp(0, 0, 0)) begin
            bad++; $display("FAIL reset_disp: got %h required %h", disp, exp_disp(0, 0, 0));
        end
        total++;
        if (pm !== 1'b0 || tick_1hz !== 1'b0) begin
            bad++; $display("FAIL reset_flags: pm=%b tick=%b required 0 0", pm, tick_1hz);
        end
        mode_12h = 1'b1;
        #1;
        e = exp_disp(12, 0, 0);
        total++;
        if (disp[41:28] !== e[41:28]) begin
            bad++; $display("FAIL reset_12h: got %h required %h", disp[41:28], e[41:28]);
        end
        mode_12h = 1'b0;
    endtask

    task automatic test_first_tick;
        int n;
        do_reset;
        n = 0;
        repeat (8) begin
            if (tick_1hz === 1'b1) n++;
            step(1);
        end
        total++;
        if (n != 1) begin
            bad++; $display("FAIL first_tick_count: got %0d required 1", n);
        end
        total++;
        if (disp !== exp_disp(0, 0, 1)) begin
            bad++; $display("FAIL first_tick_disp: got %h required %h", disp, exp_disp(0, 0, 1));
        end
    endtask

    task automatic test_rollover;
        do_reset;
        pulse_mode;
        inc_n(23);
        pulse_mode;
        inc_n(59);
        pulse_mode;
        total++;
        if (disp !== exp_disp(23, 59, 0) || pm !== 1'b1) begin
            bad++; $display("FAIL preload: got %h pm=%b required %h pm=1", disp, pm, exp_disp(23, 59, 0));
        end
        repeat (59) begin
            wait_tick;
            step(1);
        end
        wait_tick;
        total++;
        if (disp !== exp_disp(23, 59, 59) || pm !== 1'b1) begin
            bad++; $display("FAIL before_wrap: got %h pm=%b required %h pm=1", disp, pm, exp_disp(23, 59, 59));
        end
        step(1);
        total++;
        if (disp !== exp_disp(0, 0, 0) || pm !== 1'b0) begin
            bad++; $display("FAIL day_wrap: got %h pm=%b required %h pm=0", disp, pm, exp_disp(0, 0, 0));
        end
    endtask

    task automatic test_12h;
        logic [41:0] e;
        mode_12h = 1'b1;
        #1;
        e = exp_disp(12, 0, 0);
        total++;
        if (disp[41:28] !== e[41:28] || pm !== 1'b0) begin
            bad++; $display("FAIL h12_midnight: got %h pm=%b required %h pm=0", disp[41:28], pm, e[41:28]);
        end
        step(1);
        pulse_mode;
        inc_n(13);
        pulse_mode;
        pulse_mode;
        e = exp_disp(1, 0, 0);
        total++;
        if (disp !== e || pm !== 1'b1) begin
            bad++; $display("FAIL h12_13h: got %h pm=%b required %h pm=1", disp, pm, e);
        end
        mode_12h = 1'b0;
        #1;
        total++;
        if (disp !== exp_disp(13, 0, 0)) begin
            bad++; $display("FAIL h24_13h: got %h required %h", disp, exp_disp(13, 0, 0));
        end
        mode_12h = 1'b1;
        #1;
        total++;
        if (disp !== e || pm !== 1'b1) begin
            bad++; $display("FAIL h12_toggle: got %h pm=%b required %h pm=1", disp, pm, e);
        end
        mode_12h = 1'b0;
    endtask

    task automatic test_set;
        logic [41:0] e;
        logic [41:0] eb;
        int n;
        do_reset;
        step(27);
        total++;
        if (disp !== exp_disp(0, 0, 3)) begin
            bad++; $display("FAIL run_3s: got %h required %h", disp, exp_disp(0, 0, 3));
        end
        pulse_mode;
        inc_n(3);
        e = exp_disp(3, 0, 3);
        eb = {7'h7F, 7'h7F, e[27:0]};
        total++;
        if (disp !== e) begin
            bad++; $display("FAIL set_h_show: got %h required %h", disp, e);
        end
        step(3);
        total++;
        if (disp !== e) begin
            bad++; $display("FAIL blink_phase0_end: got %h required %h", disp, e);
        end
        step(1);
        total++;
        if (disp !== eb) begin
            bad++; $display("FAIL blink_phase1: got %h required %h", disp, eb);
        end
        step(3);
        total++;
        if (disp !== eb) begin
            bad++; $display("FAIL blink_phase1_end: got %h required %h", disp, eb);
        end
        step(1);
        total++;
        if (disp !== e) begin
            bad++; $display("FAIL blink_back: got %h required %h", disp, e);
        end
        pulse_mode;
        pulse_inc;
        total++;
        if (disp !== exp_disp(3, 1, 3)) begin
            bad++; $display("FAIL set_m: got %h required %h", disp, exp_disp(3, 1, 3));
        end
        pulse_mode;
        total++;
        if (disp !== exp_disp(3, 1, 0) || tick_1hz !== 1'b0) begin
            bad++; $display("FAIL leave_set: got %h tick=%b required %h tick=0", disp, tick_1hz, exp_disp(3, 1, 0));
        end
        n = 0;
        repeat (7) begin
            if (tick_1hz === 1'b1) n++;
            step(1);
        end
        total++;
        if (n != 0 || tick_1hz !== 1'b1) begin
            bad++; $display("FAIL tick_latency: early=%0d tick=%b required 0 and 1", n, tick_1hz);
        end
        step(1);
        total++;
        if (disp !== exp_disp(3, 1, 1)) begin
            bad++; $display("FAIL after_set_tick: got %h required %h", disp, exp_disp(3, 1, 1));
        end
    endtask

    task automatic test_mode_wins;
        logic [41:0] e;
        logic [41:0] eb;
        int n;
        do_reset;
        pulse_mode;
        inc_n(2);
        step(1);
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        @(negedge clock);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        e = exp_disp(2, 0, 0);
        eb = {e[41:28], 7'h7F, 7'h7F, e[13:0]};
        total++;
        if (disp !== e) begin
            bad++; $display("FAIL both_buttons: got %h required %h", disp, e);
        end
        step(4);
        total++;
        if (disp !== eb) begin
            bad++; $display("FAIL set_m_blink: got %h required %h", disp, eb);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (disp !== exp_disp(0, 0, 0)) begin
            bad++; $display("FAIL async_reset: got %h required %h", disp, exp_disp(0, 0, 0));
        end
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        repeat (8) begin
            if (tick_1hz === 1'b1) n++;
            step(1);
        end
        total++;
        if (n != 1 || disp !== exp_disp(0, 0, 1)) begin
            bad++; $display("FAIL run_after_reset: ticks=%0d got %h required 1 %h", n, disp, exp_disp(0, 0, 1));
        end
    endtask

`ifdef ALARM_EN
    task automatic test_alarm;
        do_reset;
        pulse_mode;
        pulse_mode;
        inc_n(2);
        alarm_set = 1'b1;
        @(negedge clock);
        alarm_set = 1'b0;
        inc_n(59);
        pulse_mode;
        total++;
        if (alarm !== 1'b0 || disp !== exp_disp(0, 1, 0)) begin
            bad++; $display("FAIL alarm_start: alarm=%b got %h required 0 %h", alarm, disp, exp_disp(0, 1, 0));
        end
        repeat (59) begin
            wait_tick;
            step(1);
        end
        wait_tick;
        total++;
        if (alarm !== 1'b0) begin
            bad++; $display("FAIL alarm_early: alarm=%b required 0", alarm);
        end
        step(1);
        total++;
        if (alarm !== 1'b1 || disp !== exp_disp(0, 2, 0)) begin
            bad++; $display("FAIL alarm_fire: alarm=%b got %h required 1 %h", alarm, disp, exp_disp(0, 2, 0));
        end
        step(2);
        total++;
        if (alarm !== 1'b1) begin
            bad++; $display("FAIL alarm_hold: alarm=%b required 1", alarm);
        end
        pulse_inc;
        total++;
        if (alarm !== 1'b0) begin
            bad++; $display("FAIL alarm_clear: alarm=%b required 0", alarm);
        end
        step(20);
        total++;
        if (alarm !== 1'b0) begin
            bad++; $display("FAIL alarm_stays_off: alarm=%b required 0", alarm);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_first_tick;
        test_rollover;
        test_12h;
        test_set;
        test_mode_wins;
`ifdef ALARM_EN
        test_alarm;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
